// File: rtl/ie_defs.sv
// Shared definitions for the IE execution sequencer: FSM states, select codes,
// ALU operation codes and select legality helpers.
package ie_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_STORE,
    ST_DONE
  } state_t;

  // Operand / destination select codes produced by the simple op decoder
  typedef enum logic [7:0] {
    SEL_A_REG     = 8'h01,
    SEL_X_REG     = 8'h02,
    SEL_Y_REG     = 8'h03,
    SEL_MEM_LOAD  = 8'h04,
    SEL_MEM_STORE = 8'h05,
    SEL_IMM       = 8'h06,
    SEL_ONE       = 8'h07,
    SEL_ZERO      = 8'h08
  } sel_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_INC    = 4'h2,
    ALU_PASS_B = 4'h3
  } alu_op_t;

  function automatic logic a_sel_legal(input logic [7:0] sel);
    return (sel == SEL_A_REG) || (sel == SEL_X_REG) ||
           (sel == SEL_Y_REG) || (sel == SEL_MEM_LOAD);
  endfunction

  function automatic logic b_sel_legal(input logic [7:0] sel);
    return (sel == SEL_IMM) || (sel == SEL_ONE) ||
           (sel == SEL_ZERO) || (sel == SEL_MEM_LOAD);
  endfunction

  function automatic logic out_sel_legal(input logic [7:0] sel);
    return (sel == SEL_A_REG) || (sel == SEL_X_REG) || (sel == SEL_Y_REG) ||
           (sel == SEL_MEM_STORE) || (sel == SEL_ZERO);
  endfunction

endpackage

// File: rtl/ie_mem_port.sv
// Memory request/acknowledge handshake with a bounded wait, shared by the
// LOAD and STORE phases of the sequencer.
module ie_mem_port #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        ack_seen,
  output logic        timeout
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // Wait counter: held at zero while idle so every phase starts counting from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!active || mem_ack) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LAST) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Request is a pure function of the phase so reset drops it immediately
  always_comb begin
    mem_req   = active;
    mem_we    = active && we;
    mem_addr  = active ? addr : '0;
    mem_wdata = (active && we) ? wdata : '0;
    ack_seen  = active && mem_ack;
    timeout   = active && !mem_ack && (wait_cnt == LAST);
  end

endmodule

// File: rtl/ie_exec_sequencer.sv
// Execution sequencer: accepts a decoded op bundle, optionally loads a memory
// operand, drives the external ALU for one cycle, then writes back to a
// register or stores to memory.
module ie_exec_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  alu_a_sel,
  input  logic [7:0]  alu_b_sel,
  input  logic [7:0]  alu_out_sel,
  input  logic [3:0]  alu_op_in,
  input  logic [7:0]  imm_val,
  input  logic [15:0] op_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op_out,
  input  logic [7:0]  alu_result,
  output logic [7:0]  a_reg_o,
  output logic [7:0]  x_reg_o,
  output logic [7:0]  y_reg_o,
  output logic        done,
  output logic        err
);

  import ie_defs::*;

  state_t      state, state_nxt;
  logic [7:0]  a_sel_q, b_sel_q, out_sel_q;
  logic [3:0]  op_q;
  logic [7:0]  imm_q;
  logic [15:0] addr_q;
  logic [7:0]  load_buf;
  logic [7:0]  wdata_q;
  logic [7:0]  a_q, x_q, y_q;
  logic        err_q;

  logic        accept;
  logic        sel_ok;
  logic        need_load;
  logic        mem_active;
  logic        mem_ack_seen;
  logic        mem_timeout;

  assign accept    = (state == ST_IDLE) && op_valid;
  assign sel_ok    = a_sel_legal(alu_a_sel) && b_sel_legal(alu_b_sel) &&
                     out_sel_legal(alu_out_sel);
  assign need_load = (alu_a_sel == SEL_MEM_LOAD) || (alu_b_sel == SEL_MEM_LOAD);
  assign mem_active = (state == ST_LOAD) || (state == ST_STORE);

  ie_mem_port #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (mem_active),
    .we        (state == ST_STORE),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ack_seen  (mem_ack_seen),
    .timeout   (mem_timeout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state outputs
  always_comb begin
    state_nxt  = state;
    op_ready   = 1'b0;
    done       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op_out = '0;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (!sel_ok)        state_nxt = ST_DONE;
          else if (need_load) state_nxt = ST_LOAD;
          else                state_nxt = ST_EXEC;
        end
      end
      ST_LOAD: begin
        if (mem_ack_seen)     state_nxt = ST_EXEC;
        else if (mem_timeout) state_nxt = ST_DONE;
      end
      ST_EXEC: begin
        case (a_sel_q)
          SEL_A_REG:    alu_a = a_q;
          SEL_X_REG:    alu_a = x_q;
          SEL_Y_REG:    alu_a = y_q;
          SEL_MEM_LOAD: alu_a = load_buf;
          default:      alu_a = '0;
        endcase
        case (b_sel_q)
          SEL_IMM:      alu_b = imm_q;
          SEL_ONE:      alu_b = 8'h01;
          SEL_MEM_LOAD: alu_b = load_buf;
          default:      alu_b = '0;
        endcase
        alu_op_out = op_q;
        state_nxt  = (out_sel_q == SEL_MEM_STORE) ? ST_STORE : ST_DONE;
      end
      ST_STORE: begin
        if (mem_ack_seen || mem_timeout) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bundle capture, load buffer and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      out_sel_q <= '0;
      op_q      <= '0;
      imm_q     <= '0;
      addr_q    <= '0;
      load_buf  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_sel_q   <= alu_a_sel;
        b_sel_q   <= alu_b_sel;
        out_sel_q <= alu_out_sel;
        op_q      <= alu_op_in;
        imm_q     <= imm_val;
        addr_q    <= op_addr;
        err_q     <= !sel_ok;
      end
      if ((state == ST_LOAD) && mem_ack_seen) load_buf <= mem_rdata;
      if (mem_timeout) err_q <= 1'b1;
    end
  end

  // Writeback at the end of EXEC; sources were already read combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wdata_q <= '0;
    end else if (state == ST_EXEC) begin
      case (out_sel_q)
        SEL_A_REG:     a_q     <= alu_result;
        SEL_X_REG:     x_q     <= alu_result;
        SEL_Y_REG:     y_q     <= alu_result;
        SEL_MEM_STORE: wdata_q <= alu_result;
        default:       ;
      endcase
    end
  end

  assign a_reg_o = a_q;
  assign x_reg_o = x_q;
  assign y_reg_o = y_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ie_exec_sequencer.sv
// Directed self-checking bench for ie_exec_sequencer with a behavioural ALU.
module tb_ie_exec_sequencer;

  import ie_defs::*;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  alu_a_sel, alu_b_sel, alu_out_sel;
  logic [3:0]  alu_op_in;
  logic [7:0]  imm_val;
  logic [15:0] op_addr;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op_out;
  logic [7:0]  alu_result;
  logic [7:0]  a_reg_o, x_reg_o, y_reg_o;
  logic        done, err;

  int checks   = 0;
  int failures = 0;

  ie_exec_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_out_sel(alu_out_sel),
    .alu_op_in(alu_op_in), .imm_val(imm_val), .op_addr(op_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_out(alu_op_out),
    .alu_result(alu_result), .a_reg_o(a_reg_o), .x_reg_o(x_reg_o),
    .y_reg_o(y_reg_o), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (alu_op_out)
      4'h0:    alu_result = alu_a + alu_b;
      4'h1:    alu_result = alu_a - alu_b;
      4'h2:    alu_result = alu_a + 8'h01;
      4'h3:    alu_result = alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle in IDLE; returns one cycle after acceptance
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                      input logic [3:0] op, input logic [7:0] imm, input logic [15:0] addr);
    alu_a_sel   = a;
    alu_b_sel   = b;
    alu_out_sel = o;
    alu_op_in   = op;
    imm_val     = imm;
    op_addr     = addr;
    op_valid    = 1'b1;
    tick();
    op_valid    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0;
    alu_a_sel = '0; alu_b_sel = '0; alu_out_sel = '0; alu_op_in = '0;
    imm_val = '0; op_addr = '0; mem_ack = 1'b0; mem_rdata = '0;

    #3;
    chk("rst_op_ready", {15'd0, op_ready}, 16'h1);
    chk("rst_mem_req", {15'd0, mem_req}, 16'h0);
    chk("rst_done", {15'd0, done}, 16'h0);
    chk("rst_err", {15'd0, err}, 16'h0);
    chk("rst_regs", {a_reg_o, x_reg_o}, 16'h0000);
    chk("rst_y", {8'd0, y_reg_o}, 16'h0000);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // X = 5 via immediate
    send(SEL_A_REG, SEL_IMM, SEL_X_REG, ALU_PASS_B, 8'h05, 16'h0000);
    chk("ldx_alu_b", {8'd0, alu_b}, 16'h0005);
    tick(); tick();
    chk("ldx_x", {8'd0, x_reg_o}, 16'h0005);

    // X = X + 1, register to register latency
    send(SEL_X_REG, SEL_ONE, SEL_X_REG, ALU_ADD, 8'h00, 16'h0000);
    chk("inc_exec_ready", {15'd0, op_ready}, 16'h0);
    chk("inc_exec_alu", {alu_a, alu_b}, 16'h0501);
    chk("inc_exec_req", {15'd0, mem_req}, 16'h0);
    chk("inc_exec_done", {15'd0, done}, 16'h0);
    tick();
    chk("inc_done", {15'd0, done}, 16'h1);
    chk("inc_x", {8'd0, x_reg_o}, 16'h0006);
    chk("inc_done_req", {15'd0, mem_req}, 16'h0);
    tick();
    chk("inc_c3_ready", {15'd0, op_ready}, 16'h1);
    chk("inc_c3_done", {15'd0, done}, 16'h0);

    // A = 1
    send(SEL_A_REG, SEL_ONE, SEL_A_REG, ALU_PASS_B, 8'h00, 16'h0000);
    tick(); tick();
    chk("lda_a", {8'd0, a_reg_o}, 16'h0001);

    // A = A + mem[0x0200], ack in third wait cycle
    send(SEL_A_REG, SEL_MEM_LOAD, SEL_A_REG, ALU_ADD, 8'h00, 16'h0200);
    chk("ld_req", {14'd0, mem_req, mem_we}, 16'h2);
    chk("ld_addr", mem_addr, 16'h0200);
    tick();
    chk("ld_req2", {15'd0, mem_req}, 16'h1);
    tick();
    chk("ld_req3", {15'd0, mem_req}, 16'h1);
    mem_ack = 1'b1; mem_rdata = 8'h10;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("ld_exec_req", {15'd0, mem_req}, 16'h0);
    chk("ld_exec_alu", {alu_a, alu_b}, 16'h0110);
    tick();
    chk("ld_done", {15'd0, done}, 16'h1);
    chk("ld_a", {8'd0, a_reg_o}, 16'h0011);
    tick();

    // mem[0x0300] = mem[0x0300] + 1; ack held in IDLE and first LOAD cycle
    mem_ack = 1'b1; mem_rdata = 8'h7F;
    send(SEL_MEM_LOAD, SEL_ONE, SEL_MEM_STORE, ALU_INC, 8'h00, 16'h0300);
    chk("rmw_ld_req", {15'd0, mem_req}, 16'h1);
    chk("rmw_ld_addr", mem_addr, 16'h0300);
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("rmw_exec_a", {12'd0, alu_op_out}, 16'h0002);
    chk("rmw_exec_alu_a", {8'd0, alu_a}, 16'h007F);
    tick();
    chk("rmw_st_req", {14'd0, mem_req, mem_we}, 16'h3);
    chk("rmw_st_addr", mem_addr, 16'h0300);
    chk("rmw_st_wdata", {8'd0, mem_wdata}, 16'h0080);
    chk("rmw_st_done", {15'd0, done}, 16'h0);
    tick();
    chk("rmw_st_wdata2", {8'd0, mem_wdata}, 16'h0080);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rmw_done", {14'd0, done, mem_req}, 16'h2);
    tick();
    chk("rmw_single_done", {15'd0, done}, 16'h0);
    chk("rmw_a_kept", {8'd0, a_reg_o}, 16'h0011);

    // Load timeout with MEM_TIMEOUT = 4
    send(SEL_A_REG, SEL_MEM_LOAD, SEL_A_REG, ALU_ADD, 8'h00, 16'h0400);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", {15'd0, mem_req}, 16'h1);
      tick();
    end
    chk("to_req_drop", {15'd0, mem_req}, 16'h0);
    chk("to_err_done", {14'd0, err, done}, 16'h3);
    chk("to_a_kept", {8'd0, a_reg_o}, 16'h0011);
    tick();
    chk("to_err_sticky", {15'd0, err}, 16'h1);
    send(SEL_X_REG, SEL_ONE, SEL_Y_REG, ALU_ADD, 8'h00, 16'h0000);
    chk("to_err_cleared", {15'd0, err}, 16'h0);
    tick();
    chk("to_next_y", {8'd0, y_reg_o}, 16'h0007);
    tick();

    // Reset during STORE wait
    send(SEL_X_REG, SEL_IMM, SEL_MEM_STORE, ALU_ADD, 8'h03, 16'h0500);
    tick();
    chk("rs_st_wdata", {8'd0, mem_wdata}, 16'h0009);
    chk("rs_st_req", {15'd0, mem_req}, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_mem_zero", {14'd0, mem_req, mem_we}, 16'h0);
    chk("rs_addr_zero", mem_addr, 16'h0000);
    chk("rs_wdata_zero", {8'd0, mem_wdata}, 16'h0000);
    chk("rs_alu_zero", {alu_a, alu_b}, 16'h0000);
    chk("rs_regs_zero", {a_reg_o, x_reg_o}, 16'h0000);
    chk("rs_y_zero", {8'd0, y_reg_o}, 16'h0000);
    chk("rs_flags", {13'd0, op_ready, done, err}, 16'h4);
    alu_a_sel = SEL_X_REG; alu_b_sel = SEL_ONE; alu_out_sel = SEL_X_REG;
    alu_op_in = ALU_ADD; op_valid = 1'b1; mem_ack = 1'b1;
    tick();
    chk("rs_valid_ignored", {15'd0, op_ready}, 16'h1);
    op_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rs_late_ack", {14'd0, mem_req, done}, 16'h0);
    chk("rs_idle_ready", {15'd0, op_ready}, 16'h1);
    mem_ack = 1'b0;
    tick();
    chk("rs_x_kept", {8'd0, x_reg_o}, 16'h0000);

    // Illegal a select
    send(SEL_IMM, SEL_ONE, SEL_X_REG, ALU_ADD, 8'h55, 16'h0000);
    chk("ill_done_err", {14'd0, done, err}, 16'h3);
    chk("ill_no_req", {15'd0, mem_req}, 16'h0);
    tick();
    chk("ill_idle", {13'd0, op_ready, done, err}, 16'h5);
    chk("ill_x_kept", {8'd0, x_reg_o}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
